// File: rtl/rc4_pkg.sv
// Shared constants and FSM state encoding for the RC4 key-scheduling blocks.
package rc4_pkg;

  localparam int SBOX_SIZE = 256;
  localparam int BYTE_W    = 8;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [3:0]        state_t;

  localparam state_t IDLE   = 4'd0;
  localparam state_t INIT   = 4'd1;
  localparam state_t RD_SI  = 4'd2;
  localparam state_t LD_SI  = 4'd3;
  localparam state_t CALC_J = 4'd4;
  localparam state_t RD_SJ  = 4'd5;
  localparam state_t LD_SJ  = 4'd6;
  localparam state_t WR_I   = 4'd7;
  localparam state_t WR_J   = 4'd8;
  localparam state_t FIN    = 4'd9;

  localparam byte_t I_LAST = byte_t'(SBOX_SIZE - 1);

endpackage

// File: rtl/rc4_key_idx.sv
// Wrapping key-buffer index: clr_i captures the key length and zeroes the index,
// inc_i steps it and wraps after the last key byte without a modulo divider.
module rc4_key_idx #(
  parameter int KEY_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic [KEY_AW:0]   len_i,
  input  logic              inc_i,
  output logic [KEY_AW-1:0] idx_o
);

  logic [KEY_AW-1:0] idx_q, idx_d;
  logic [KEY_AW-1:0] last_q, last_d;
  logic [KEY_AW:0]   len_m1;

  assign len_m1 = len_i - 1'b1;

  always_comb begin
    idx_d  = idx_q;
    last_d = last_q;
    if (clr_i) begin
      idx_d  = '0;
      // A zero length behaves like a single-byte key.
      last_d = (len_i == '0) ? '0 : len_m1[KEY_AW-1:0];
    end else if (inc_i) begin
      idx_d = (idx_q == last_q) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      last_q <= '0;
    end else begin
      idx_q  <= idx_d;
      last_q <= last_d;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/rc4_ksa_ctrl.sv
// RC4 key-scheduling sequencer: fills the S-box, drives cal_j, swaps S[i]/S[j].
// Optional RC4_KSA_ABORT_EN adds an abort_i input that cancels a run.
module rc4_ksa_ctrl
  import rc4_pkg::*;
#(
  parameter int KEY_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [KEY_AW:0]   key_len_i,
`ifdef RC4_KSA_ABORT_EN
  input  logic              abort_i,
`endif
  output logic [KEY_AW-1:0] key_addr_o,
  input  logic [7:0]        key_data_i,
  output logic              j_en_o,
  output logic [7:0]        j_key_o,
  output logic [7:0]        j_si_o,
  output logic [7:0]        j_prev_o,
  input  logic [7:0]        j_in_i,
  output logic [7:0]        s_addr_o,
  output logic [7:0]        s_wdata_o,
  output logic              s_we_o,
  input  logic [7:0]        s_rdata_i,
  output logic              busy_o,
  output logic              done_o
);

  state_t            state_q, state_d;
  byte_t             i_q, i_d;
  byte_t             si_q, si_d;
  byte_t             jj_q, jj_d;
  byte_t             sj_q, sj_d;
  logic              kidx_clr, kidx_inc;
  logic [KEY_AW-1:0] kidx;
  logic              abort;

`ifdef RC4_KSA_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  rc4_key_idx #(.KEY_AW(KEY_AW)) u_key_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (kidx_clr),
    .len_i (key_len_i),
    .inc_i (kidx_inc),
    .idx_o (kidx)
  );

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    si_d     = si_q;
    jj_d     = jj_q;
    sj_d     = sj_q;
    kidx_clr = 1'b0;
    kidx_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = INIT;
          i_d      = '0;
          kidx_clr = 1'b1;
        end
      end
      INIT: begin
        // i wraps back to 0 as the fill finishes, ready for the swap loop.
        i_d = i_q + 1'b1;
        if (i_q == I_LAST) state_d = RD_SI;
      end
      RD_SI:  state_d = LD_SI;
      LD_SI: begin
        si_d    = s_rdata_i;
        state_d = CALC_J;
      end
      CALC_J: state_d = RD_SJ;
      RD_SJ: begin
        jj_d    = j_in_i;
        state_d = LD_SJ;
      end
      LD_SJ: begin
        sj_d    = s_rdata_i;
        state_d = WR_I;
      end
      WR_I:   state_d = WR_J;
      WR_J: begin
        if (i_q == I_LAST) begin
          state_d = FIN;
        end else begin
          i_d      = i_q + 1'b1;
          kidx_inc = 1'b1;
          state_d  = RD_SI;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      si_q    <= '0;
      jj_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      si_q    <= si_d;
      jj_q    <= jj_d;
      sj_q    <= sj_d;
    end
  end

  // Outputs decode from registered state so an async reset clears them at once.
  always_comb begin
    key_addr_o = '0;
    j_en_o     = 1'b0;
    j_key_o    = '0;
    j_si_o     = '0;
    j_prev_o   = '0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_we_o     = 1'b0;
    case (state_q)
      INIT: begin
        s_we_o    = 1'b1;
        s_addr_o  = i_q;
        s_wdata_o = i_q;
      end
      RD_SI: begin
        s_addr_o   = i_q;
        key_addr_o = kidx;
      end
      LD_SI: begin
        j_en_o   = 1'b1;
        j_key_o  = key_data_i;
        j_si_o   = s_rdata_i;
        j_prev_o = (i_q == '0) ? '0 : j_in_i;
      end
      RD_SJ: s_addr_o = j_in_i;
      WR_I: begin
        s_we_o    = 1'b1;
        s_addr_o  = i_q;
        s_wdata_o = sj_q;
      end
      WR_J: begin
        s_we_o    = 1'b1;
        s_addr_o  = jj_q;
        s_wdata_o = si_q;
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == FIN) && !abort;

endmodule

// File: tb/tb_rc4_ksa_ctrl.sv
// Bench for rc4_ksa_ctrl with an ideal 1-cycle S-box RAM, key buffer and cal_j stage.
module tb_rc4_ksa_ctrl;

  localparam int KEY_AW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [KEY_AW:0]   key_len;
  logic [KEY_AW-1:0] key_addr;
  logic [7:0]        key_data;
  logic              j_en;
  logic [7:0]        j_key, j_si, j_prev, j_in;
  logic [7:0]        s_addr, s_wdata, s_rdata;
  logic              s_we, busy, done;
`ifdef RC4_KSA_ABORT_EN
  logic              abort;
`endif

  always #5 clk = ~clk;

  rc4_ksa_ctrl #(.KEY_AW(KEY_AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .key_len_i  (key_len),
`ifdef RC4_KSA_ABORT_EN
    .abort_i    (abort),
`endif
    .key_addr_o (key_addr),
    .key_data_i (key_data),
    .j_en_o     (j_en),
    .j_key_o    (j_key),
    .j_si_o     (j_si),
    .j_prev_o   (j_prev),
    .j_in_i     (j_in),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .s_we_o     (s_we),
    .s_rdata_i  (s_rdata),
    .busy_o     (busy),
    .done_o     (done)
  );

  logic [7:0] sram [256];
  logic [7:0] kmem [256];
  logic [7:0] ref_s [256];
  logic [7:0] cal_j_q;

  always @(posedge clk) begin
    if (s_we) sram[s_addr] <= s_wdata;
    s_rdata  <= sram[s_addr];
    key_data <= kmem[key_addr];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cal_j_q <= 8'h00;
    else if (j_en) cal_j_q <= j_prev + j_si + j_key;
  end
  assign j_in = cal_j_q;

  logic [51:0] outs;
  assign outs = {busy, done, s_we, j_en, s_addr, s_wdata, key_addr, j_key, j_si, j_prev};

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  typedef struct {
    logic [8:0] len;   // value driven on key_len
    int         mlen;  // key length the reference algorithm uses
    logic [7:0] k0, k1, k2;
    bit         pat;   // key[n] = n over the whole buffer
    int         ks;    // expected first keystream byte, -1 = not checked
  } vec_t;

  vec_t vecs [5];

  task automatic load_key(input vec_t v);
    for (int n = 0; n < 256; n++) kmem[n] = v.pat ? n[7:0] : (8'hA5 ^ n[7:0]);
    if (!v.pat) begin
      kmem[0] = v.k0;
      if (v.mlen > 1) kmem[1] = v.k1;
      if (v.mlen > 2) kmem[2] = v.k2;
    end
  endtask

  task automatic ref_ksa(input int len);
    logic [7:0] j, t;
    for (int n = 0; n < 256; n++) ref_s[n] = n[7:0];
    j = 8'h00;
    for (int n = 0; n < 256; n++) begin
      j = j + ref_s[n] + kmem[n % len];
      t = ref_s[n];
      ref_s[n] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  task automatic sbox_check(input string name);
    int bad;
    bad = 0;
    for (int n = 0; n < 256; n++) if (sram[n] !== ref_s[n]) bad++;
    check(name, bad, 0);
  endtask

  task automatic prga1(output logic [7:0] ks);
    logic [7:0] s [256];
    logic [7:0] j, t, idx;
    for (int n = 0; n < 256; n++) s[n] = sram[n];
    j = s[1];
    t = s[1]; s[1] = s[j]; s[j] = t;
    idx = s[1] + s[j];
    ks = s[idx];
  endtask

  // cnt is the cycle index with the start cycle as 1; lat is the cycle showing done.
  // ev_kind 1 drops rst_n during cycle ev_at, ev_kind 2 raises abort during it.
  task automatic run_ksa(input logic [8:0] len, input int pa, input int pb,
                         input int ev_at, input int ev_kind,
                         output int lat, output int dones);
    int cnt, stray_we, stray_done;
    @(negedge clk);
    key_len = len;
    start   = 1'b1;
    lat     = -1;
    dones   = 0;
    cnt     = 1;
    for (int guard = 0; guard < 2300; guard++) begin
      @(posedge clk); #1;
      cnt++;
      start = (cnt == pa) || (cnt == pb);
      if (done) begin
        dones++;
        if (lat < 0) lat = cnt;
      end
      if (cnt == 2) check("busy_after_start", busy, 1'b1);
      if (lat >= 0 && cnt == lat + 1) check("busy_after_done", {busy, done}, 2'b00);
      if (lat >= 0 && cnt >= lat + 12) break;
      if (cnt == ev_at && ev_kind == 1) begin
        rst_n = 1'b0;
        #1;
        check("outs_in_reset_cycle", outs, 52'h0);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
`ifdef RC4_KSA_ABORT_EN
      if (cnt == ev_at && ev_kind == 2) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_next_cycle", {busy, done, s_we}, 3'b000);
        stray_we   = 0;
        stray_done = 0;
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); #1;
          if (s_we) stray_we++;
          if (done) stray_done++;
        end
        check("abort_quiet", stray_we + stray_done, 0);
        break;
      end
`endif
    end
    start = 1'b0;
    if (lat < 0 && ev_kind == 0) $display("FAIL run_bound no done within cycle budget");
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  int lat, dones;
  logic [7:0] ks;

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    key_len = '0;
`ifdef RC4_KSA_ABORT_EN
    abort   = 1'b0;
`endif
    vecs[0] = '{9'd1,   1,   8'h00, 8'h00, 8'h00, 1'b0, -1};
    vecs[1] = '{9'd3,   3,   8'h4B, 8'h65, 8'h79, 1'b0, 'hEB};
    vecs[2] = '{9'd0,   1,   8'h00, 8'h00, 8'h00, 1'b0, -1};
    vecs[3] = '{9'd256, 256, 8'h00, 8'h00, 8'h00, 1'b1, -1};
    vecs[4] = '{9'd2,   2,   8'h01, 8'h02, 8'h00, 1'b0, -1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs, 52'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outs", outs, 52'h0);

    for (int v = 0; v < 5; v++) begin
      load_key(vecs[v]);
      ref_ksa(vecs[v].mlen);
      run_ksa(vecs[v].len, -1, -1, -1, 0, lat, dones);
      check($sformatf("v%0d_latency", v), lat, 2050);
      check($sformatf("v%0d_done_count", v), dones, 1);
      sbox_check($sformatf("v%0d_sbox", v));
      if (vecs[v].ks >= 0) begin
        prga1(ks);
        check($sformatf("v%0d_keystream0", v), ks, vecs[v].ks[7:0]);
      end
    end

    // Stray start pulses in INIT (i=9) and in WR_J (i=5).
    load_key(vecs[1]);
    ref_ksa(3);
    run_ksa(9'd3, 11, 299, -1, 0, lat, dones);
    check("stray_start_latency", lat, 2050);
    check("stray_start_done_count", dones, 1);
    sbox_check("stray_start_sbox");

    // Reset mid-run, then a clean rerun.
    run_ksa(9'd3, -1, -1, 1000, 1, lat, dones);
    check("reset_run_no_done", dones, 0);
    @(posedge clk); #1;
    check("after_reset_idle", outs, 52'h0);
    run_ksa(9'd3, -1, -1, -1, 0, lat, dones);
    check("post_reset_latency", lat, 2050);
    sbox_check("post_reset_sbox");

`ifdef RC4_KSA_ABORT_EN
    // Abort in RD_SJ at i=10, then restart.
    run_ksa(9'd3, -1, -1, 331, 2, lat, dones);
    check("abort_no_done", dones, 0);
    run_ksa(9'd3, -1, -1, -1, 0, lat, dones);
    check("post_abort_latency", lat, 2050);
    sbox_check("post_abort_sbox");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
